addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pipe.sv | 185 ++++++++++++++++++
 tb/tb_addsub_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Segmented-carry pipelined signed adder/subtractor with optional saturation.
// Each stage adds one SEG-bit slice and passes its carry to the next stage.
// The pipeline uses a valid/ready handshake: the whole pipe advances together
// when the output register is empty or being drained.
`timescale 1ns/1ps
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = WIDTH / SEG;
  localparam int L      = STAGES - 1;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_param
    $error("addsub_pipe: WIDTH must be a positive multiple of SEG");
  end

  // SEG-bit slice add with carry in; MSB of the result is the slice carry out.
  function automatic logic [SEG:0] add_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           cin);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, cin};
  endfunction

  // Clamp toward the side the true result overflowed to; raw MSB 1 means the
  // true result was too large positive.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic             ovf,
                                                input logic             en);
    if (en && ovf)
      return raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    return raw;
  endfunction

  logic              advance;
  logic [STAGES-1:0] vld_d, vld_q;
  logic [STAGES-1:0] carry_d, carry_q;
  logic [STAGES-1:0] sub_d, sub_q;
  logic [STAGES-1:0] sat_d, sat_q;
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];

  logic              out_valid_d, out_valid_q;
  logic [WIDTH-1:0]  s_d, s_q;
  logic              cout_d, cout_q;
  logic              ovf_d, ovf_q;
  logic              zero_d, zero_q;
  logic              neg_d, neg_q;

  logic [SEG:0]      seg_last;
  logic [WIDTH-1:0]  raw;
  logic              c_msb_in;
  logic              raw_ovf;
  logic [WIDTH-1:0]  s_fin;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Stage registers: capture the operands, then add one slice per stage.
  always_comb begin
    logic [SEG:0] seg_sum;
    seg_sum = '0;
    vld_d   = vld_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    sat_d   = sat_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
    end
    if (advance) begin
      vld_d[0]   = in_valid;
      a_d[0]     = a;
      b_d[0]     = b;
      sub_d[0]   = sub;
      sat_d[0]   = sat;
      carry_d[0] = sub;
      sum_d[0]   = '0;
      for (int k = 1; k < STAGES; k++) begin
        seg_sum = add_seg(a_q[k-1][(k-1)*SEG +: SEG],
                          b_q[k-1][(k-1)*SEG +: SEG] ^ {SEG{sub_q[k-1]}},
                          carry_q[k-1]);
        vld_d[k]   = vld_q[k-1];
        a_d[k]     = a_q[k-1];
        b_d[k]     = b_q[k-1];
        sub_d[k]   = sub_q[k-1];
        sat_d[k]   = sat_q[k-1];
        carry_d[k] = seg_sum[SEG];
        sum_d[k]   = sum_q[k-1];
        sum_d[k][(k-1)*SEG +: SEG] = seg_sum[SEG-1:0];
      end
    end
  end

  // Final slice, flags and saturation feeding the output register.
  always_comb begin
    seg_last = add_seg(a_q[L][L*SEG +: SEG],
                       b_q[L][L*SEG +: SEG] ^ {SEG{sub_q[L]}},
                       carry_q[L]);
    raw = sum_q[L];
    raw[L*SEG +: SEG] = seg_last[SEG-1:0];
    c_msb_in = a_q[L][WIDTH-1] ^ (b_q[L][WIDTH-1] ^ sub_q[L]) ^ raw[WIDTH-1];
    raw_ovf  = c_msb_in ^ seg_last[SEG];
    s_fin    = saturate(raw, raw_ovf, sat_q[L]);

    out_valid_d = out_valid_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    if (advance) begin
      out_valid_d = vld_q[L];
      if (vld_q[L]) begin
        s_d    = s_fin;
        cout_d = seg_last[SEG];
        ovf_d  = raw_ovf;
        zero_d = (s_fin == '0);
        neg_d  = s_fin[WIDTH-1];
      end
    end
  end

  // Valid bits and output register: cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  // Stage datapath registers; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    carry_q <= carry_d;
    sub_q   <= sub_d;
    sat_q   <= sat_d;
    for (int k = 0; k < STAGES; k++) begin
      a_q[k]   <= a_d[k];
      b_q[k]   <= b_d[k];
      sum_q[k] <= sum_d[k];
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Testbench for addsub_pipe (WIDTH=16, SEG=4): directed vectors plus an
// arithmetic reference model with a per-cycle scoreboard compare.
`timescale 1ns/1ps
module tb_addsub_pipe;
  localparam int W   = 16;
  localparam int SG  = 4;
  localparam int STG = W / SG;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, sub, sat, out_valid, out_ready;
  logic [W-1:0] a, b, s;
  logic         cout, overflow, zero, neg;

  addsub_pipe #(.WIDTH(W), .SEG(SG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .sat(sat), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .overflow(overflow),
    .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] s;
    logic        cout, ovf, zero, neg;
    int          acc;
    int          st;
  } exp_t;

  exp_t q[$];

  // Reference: true signed result decides overflow/saturation, unsigned sum of
  // A and the (inverted for sub) B operand decides the carry.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic sv, input logic satv);
    exp_t e;
    int sa, sb, tru, u;
    sa  = int'($signed(av));
    sb  = int'($signed(bv));
    tru = sv ? sa - sb : sa + sb;
    u   = sv ? int'(av) + (65535 - int'(bv)) + 1 : int'(av) + int'(bv);
    e.ovf  = (tru > 32767) || (tru < -32768);
    e.cout = (u > 65535);
    e.s    = (satv && e.ovf) ? ((tru > 0) ? 16'h7FFF : 16'h8000) : u[15:0];
    e.zero = (e.s == 16'h0000);
    e.neg  = e.s[15];
    e.acc  = 0;
    e.st   = 0;
    return e;
  endfunction

  int          cyc = 0;
  int          stalls = 0;
  int          delivered = 0;
  logic        prev_stall = 1'b0;
  logic [19:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: handshake, timing and values of every presented beat.
  always @(negedge clk) begin
    logic exp_v;
    exp_t e;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      exp_v = (q.size() > 0) && (cyc == q[0].acc + STG + (stalls - q[0].st));
      chk("out_valid_timing", {31'd0, out_valid}, {31'd0, exp_v});
      if (out_valid && q.size() > 0) begin
        chk("s", {16'd0, s}, {16'd0, q[0].s});
        chk("cout", {31'd0, cout}, {31'd0, q[0].cout});
        chk("overflow", {31'd0, overflow}, {31'd0, q[0].ovf});
        chk("zero", {31'd0, zero}, {31'd0, q[0].zero});
        chk("neg", {31'd0, neg}, {31'd0, q[0].neg});
        if (out_ready) begin
          void'(q.pop_front());
          delivered++;
        end
      end
      if (prev_stall && out_valid)
        chk("stall_stable", {12'd0, s, cout, overflow, zero, neg}, {12'd0, held});
      prev_stall = out_valid && !out_ready;
      held = {s, cout, overflow, zero, neg};
      if (prev_stall) stalls++;
      if (in_valid && in_ready) begin
        e = model(a, b, sub, sat);
        e.acc = cyc + 1;
        e.st  = stalls;
        q.push_back(e);
      end
    end
  end

  // One isolated beat with hand-computed results and exact latency.
  task automatic single(input string nm, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic satv, input logic [15:0] es,
                        input logic ec, input logic eo, input logic ez, input logic en);
    @(posedge clk); #1;
    in_valid = 1'b1; a = av; b = bv; sub = sv; sat = satv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({nm, "_early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_s"}, {16'd0, s}, {16'd0, es});
    chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({nm, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, ez});
    chk({nm, "_neg"}, {31'd0, neg}, {31'd0, en});
  endtask

  logic [15:0] ta [8] = '{16'h1234, 16'h7FFF, 16'h8000, 16'h00FF,
                          16'hFFFF, 16'h4000, 16'h0F0F, 16'h8001};
  logic [15:0] tb [8] = '{16'h4321, 16'h7FFF, 16'h0001, 16'h0001,
                          16'h0001, 16'h4000, 16'hF0F0, 16'h7FFF};
  logic [7:0]  tsub = 8'b1100_1100;
  logic [7:0]  tsat = 8'b1010_0110;

  task automatic stream();
    int idx;
    int base;
    idx  = 0;
    base = delivered;
    for (int i = 0; i < 60 && idx < 8; i++) begin
      @(posedge clk); #1;
      out_ready = !(i >= 5 && i < 8);
      in_valid  = 1'b1;
      a = ta[idx]; b = tb[idx]; sub = tsub[idx]; sat = tsat[idx];
      @(negedge clk);
      if (i == 6) chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      if (in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 40 && delivered < base + 8; w++) @(negedge clk);
    chk("stream_count", delivered - base, 32'd8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flags", {16'd0, s, cout, overflow, zero, neg}, 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    single("plain_add",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    single("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    single("pos_ovf_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    single("neg_ovf_sat", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    single("sub_zero",    16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    single("wrap_zero",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    stream();

    // Fill the pipe, then reset asynchronously with beats in flight.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 16'h0100 + 16'(i); b = 16'h0010; sub = 1'b0; sat = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1 chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_beat", {31'd0, out_valid}, 32'd0);
    end
    single("post_rst",    16'h0003, 16'h0007, 1'b1, 1'b0, 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
